// File: rtl/elevator_door.sv
// Elevator door controller: timed open/dwell/close sequencing with obstruction
// reversal, button overrides, served-floor pulse and a sticky motion fault.
module elevator_door #(
  parameter int unsigned MOVE_T  = 4,
  parameter int unsigned DWELL_T = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] q,
  input  logic       moving,
  input  logic       stop_req,
  input  logic       open_btn,
  input  logic       close_btn,
  input  logic       obstruct,
  output logic [1:0] door_state,
  output logic       door_open,
  output logic       door_busy,
  output logic [7:0] served,
  output logic       fault
);

  localparam logic [7:0] MOVE_LD  = 8'(MOVE_T - 1);
  localparam logic [7:0] DWELL_LD = 8'(DWELL_T - 1);

  typedef enum logic [1:0] {
    CLOSED  = 2'b00,
    OPENING = 2'b01,
    OPEN    = 2'b10,
    CLOSING = 2'b11
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       open_q, open_d;
  logic       busy_q, busy_d;
  logic [7:0] served_q, served_d;
  logic       fault_q, fault_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= CLOSED;
      timer_q  <= 8'd0;
      open_q   <= 1'b0;
      busy_q   <= 1'b0;
      served_q <= 8'h00;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      open_q   <= open_d;
      busy_q   <= busy_d;
      served_q <= served_d;
      fault_q  <= fault_d;
    end
  end

  // Reopen requests (obstruct/open_btn) dominate close_btn and timer expiry.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      CLOSED: begin
        if (!moving && (stop_req || open_btn)) begin
          state_d = OPENING;
          timer_d = MOVE_LD;
        end
      end
      OPENING: begin
        if (timer_q == 8'd0) begin
          state_d = OPEN;
          timer_d = DWELL_LD;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      OPEN: begin
        if (obstruct || open_btn) begin
          timer_d = DWELL_LD;
        end else if (close_btn || (timer_q == 8'd0)) begin
          state_d = CLOSING;
          timer_d = MOVE_LD;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      CLOSING: begin
        if (obstruct || open_btn) begin
          state_d = OPENING;
          timer_d = MOVE_LD;
        end else if (timer_q == 8'd0) begin
          state_d = CLOSED;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      default: begin
        state_d = CLOSED;
        timer_d = 8'd0;
      end
    endcase
  end

  // Outputs are derived from the next state so the registered copies line up
  // with door_state in the same cycle.
  always_comb begin
    open_d   = (state_d == OPEN);
    busy_d   = (state_d != CLOSED);
    served_d = ((state_q == OPENING) && (timer_q == 8'd0)) ? q : 8'h00;
    fault_d  = fault_q || (moving && (state_q != CLOSED));
  end

  assign door_state = state_q;
  assign door_open  = open_q;
  assign door_busy  = busy_q;
  assign served     = served_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_elevator_door.sv
// Bench for elevator_door: directed scenarios plus randomized traffic against a
// phase/elapsed-time reference model.
module tb_elevator_door;

  localparam int MOVE_T  = 4;
  localparam int DWELL_T = 10;
  localparam int P_CLOSED = 0, P_OPENING = 1, P_OPEN = 2, P_CLOSING = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] q;
  logic       moving, stop_req, open_btn, close_btn, obstruct;
  logic [1:0] door_state;
  logic       door_open, door_busy, fault;
  logic [7:0] served;

  int n_vec = 0;
  int n_err = 0;

  int         m_phase;
  int         m_elapsed;
  logic [7:0] m_served;
  logic       m_fault;

  elevator_door #(.MOVE_T(MOVE_T), .DWELL_T(DWELL_T)) dut (
    .clk(clk), .reset(reset), .q(q), .moving(moving), .stop_req(stop_req),
    .open_btn(open_btn), .close_btn(close_btn), .obstruct(obstruct),
    .door_state(door_state), .door_open(door_open), .door_busy(door_busy),
    .served(served), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase   = P_CLOSED;
    m_elapsed = 0;
    m_served  = 8'h00;
    m_fault   = 1'b0;
  endtask

  // One clock of behaviour: elapsed counts cycles spent in the current phase
  // (or since the last dwell restart) and is compared against the phase length.
  task automatic model_step();
    if (moving && m_phase != P_CLOSED) m_fault = 1'b1;
    m_served = 8'h00;
    case (m_phase)
      P_CLOSED:
        if (!moving && (stop_req || open_btn)) begin
          m_phase = P_OPENING; m_elapsed = 0;
        end
      P_OPENING:
        if (m_elapsed == MOVE_T - 1) begin
          m_phase = P_OPEN; m_elapsed = 0; m_served = q;
        end else m_elapsed++;
      P_OPEN:
        if (obstruct || open_btn) m_elapsed = 0;
        else if (close_btn || m_elapsed == DWELL_T - 1) begin
          m_phase = P_CLOSING; m_elapsed = 0;
        end else m_elapsed++;
      default:
        if (obstruct || open_btn) begin
          m_phase = P_OPENING; m_elapsed = 0;
        end else if (m_elapsed == MOVE_T - 1) begin
          m_phase = P_CLOSED; m_elapsed = 0;
        end else m_elapsed++;
    endcase
  endtask

  task automatic check_all();
    chk("door_state", 32'(door_state), 32'(m_phase));
    chk("door_open",  32'(door_open),  32'(m_phase == P_OPEN));
    chk("door_busy",  32'(door_busy),  32'(m_phase != P_CLOSED));
    chk("served",     32'(served),     32'(m_served));
    chk("fault",      32'(fault),      32'(m_fault));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic clear_inputs();
    moving = 0; stop_req = 0; open_btn = 0; close_btn = 0; obstruct = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 reset = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int bound);
    int n = 0;
    while (door_state !== s && n < bound) begin
      tick();
      n++;
    end
    chk("wait_state", 32'(door_state), 32'(s));
  endtask

  task automatic open_door(input logic [7:0] fl);
    q = fl;
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    wait_state(2'b10, 20);
  endtask

  initial begin
    int busy_cnt, srv_cnt, n;
    logic [7:0] srv_val;

    reset = 1'b1;
    q = 8'h01;
    clear_inputs();
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // Full cycle timing and single served pulse
    do_reset();
    q = 8'h04;
    stop_req = 1'b1;
    busy_cnt = 0; srv_cnt = 0; srv_val = 8'h00;
    for (int i = 0; i < 30; i++) begin
      tick();
      stop_req = 1'b0;
      if (door_busy) busy_cnt++;
      if (served != 8'h00) begin srv_cnt++; srv_val = served; end
    end
    chk("busy_cycles", 32'(busy_cnt), 32'd18);
    chk("served_count", 32'(srv_cnt), 32'd1);
    chk("served_value", 32'(srv_val), 32'h04);

    // Held obstruction keeps the door open, dwell restarts on release
    open_door(8'h10);
    obstruct = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("obstruct_hold", 32'(door_state), 32'd2);
    obstruct = 1'b0;
    n = 0;
    while (door_state !== 2'b11 && n < 30) begin tick(); n++; end
    chk("dwell_after_obstruct", 32'(n), 32'(DWELL_T));

    // Reversal late in CLOSING, then a second served pulse
    tick(); tick();
    obstruct = 1'b1;
    tick();
    obstruct = 1'b0;
    chk("reverse_to_opening", 32'(door_state), 32'd1);
    wait_state(2'b10, 10);
    chk("second_served", 32'(served), 32'h10);
    wait_state(2'b00, 40);

    // close_btn shortens dwell; combined with open_btn it is ignored
    open_door(8'h02);
    tick(); tick();
    close_btn = 1'b1;
    tick();
    close_btn = 1'b0;
    chk("close_btn", 32'(door_state), 32'd3);
    wait_state(2'b00, 20);
    open_door(8'h02);
    tick(); tick();
    close_btn = 1'b1; open_btn = 1'b1;
    tick();
    close_btn = 1'b0; open_btn = 1'b0;
    chk("open_beats_close", 32'(door_state), 32'd2);
    wait_state(2'b00, 40);

    // Motion interlock and sticky fault
    do_reset();
    moving = 1'b1; stop_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("moving_closed_state", 32'(door_state), 32'd0);
    chk("moving_closed_fault", 32'(fault), 32'd0);
    clear_inputs();
    open_door(8'h80);
    moving = 1'b1;
    tick();
    moving = 1'b0;
    chk("fault_set", 32'(fault), 32'd1);
    for (int i = 0; i < 30; i++) tick();
    chk("fault_sticky", 32'(fault), 32'd1);

    // Asynchronous reset between edges mid-OPENING
    do_reset();
    q = 8'h08; stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    tick();
    @(posedge clk);
    model_step();
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async_state", 32'(door_state), 32'd0);
    chk("async_busy", 32'(door_busy), 32'd0);
    check_all();
    #1 reset = 1'b0;
    tick();

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 499) do_reset();
      q         = ($urandom_range(0, 7) == 0) ? 8'($urandom) : (8'h01 << $urandom_range(0, 7));
      stop_req  = ($urandom_range(0, 3) == 0);
      open_btn  = ($urandom_range(0, 9) == 0);
      close_btn = ($urandom_range(0, 7) == 0);
      obstruct  = ($urandom_range(0, 9) == 0);
      moving    = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
